// File: rtl/mac_operand_sequencer_if.sv
// Operand-pair input stream for mac_operand_sequencer.
//   in_valid : producer has a valid A/B pair on in_a/in_b
//   in_ready : sequencer FIFO can accept a pair this cycle
//   in_a     : operand A (8 bits)
//   in_b     : operand B (8 bits)
// master = producer side, slave = sequencer side.
interface mac_operand_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds operand pairs from a small FIFO to a downstream multiply-accumulate
// unit, one dot product at a time.
//   clk, rst  : clock; synchronous active-high reset
//   start/len : one-cycle request to run a dot product of len pairs
//   in_if     : operand-pair input stream (valid/ready, in_a, in_b)
//   mac_a/b   : registered operands, zero unless mac_en is high
//   mac_en    : accumulate mac_a*mac_b this cycle
//   mac_clr   : one-cycle accumulator clear at the start of a dot product
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle pulse, coincident with the final mac_en
//   remaining : pairs still to be issued in the current dot product
module mac_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  mac_operand_sequencer_if.slave  in_if,
  output logic [7:0]              mac_a,
  output logic [7:0]              mac_b,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_W-1:0]        remaining
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  mem_a [DEPTH];
  logic [7:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Ready and pop both look only at registered occupancy, so a pair pushed
  // on an edge can never be popped on that same edge.
  assign in_if.in_ready = (count != FULL_COUNT);
  assign push = in_if.in_valid && in_if.in_ready;
  assign pop  = (state == RUN) && (count != '0) && (remaining != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_a[wr_ptr] <= in_if.in_a;
      mem_b[wr_ptr] <= in_if.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mac_a   <= '0;
      mac_b   <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            mac_clr   <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            mac_a     <= mem_a[rd_ptr];
            mac_b     <= mem_b[rd_ptr];
            mac_en    <= 1'b1;
            remaining <= remaining - 1'b1;
            // The final pop raises done together with its mac_en.
            if (remaining == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             mac_en;
  logic             mac_clr;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] remaining;

  mac_operand_sequencer_if bus();

  mac_operand_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_if     (bus),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; the phase of the job is inferred
  // from the outputs the model itself expects for the cycle just ended.
  logic [15:0]      q[$];
  logic             e_en = 1'b0;
  logic             e_clr = 1'b0;
  logic             e_busy = 1'b0;
  logic             e_done = 1'b0;
  logic [7:0]       e_a = '0;
  logic [7:0]       e_b = '0;
  logic [LEN_W-1:0] e_rem = '0;
  bit               chk_on = 1'b0;
  int               cyc = 0;

  always @(posedge clk) begin
    bit was_idle, was_clear, was_run, was_done, take;
    logic [15:0] pr;
    cyc++;
    if (rst) begin
      q.delete();
      e_en = 0; e_clr = 0; e_busy = 0; e_done = 0;
      e_a = '0; e_b = '0; e_rem = '0;
      chk_on = 1'b1;
    end else begin
      was_idle  = !e_busy;
      was_clear = e_clr;
      was_done  = e_done;
      was_run   = e_busy && !e_clr && !e_done;
      take      = bus.in_valid && (q.size() < DEPTH);
      e_en = 0; e_clr = 0; e_done = 0; e_a = '0; e_b = '0;
      if (was_idle && start) begin
        e_rem  = len;
        e_clr  = 1;
        e_busy = 1;
      end
      if (was_clear && e_rem == 0) e_done = 1;
      if (was_run && e_rem != 0 && q.size() != 0) begin
        pr    = q.pop_front();
        e_en  = 1;
        e_a   = pr[15:8];
        e_b   = pr[7:0];
        e_rem = e_rem - 1'b1;
        if (e_rem == 0) e_done = 1;
      end
      if (was_done) e_busy = 0;
      if (take) q.push_back({bus.in_a, bus.in_b});
    end
  end

  // Monitor state used by the directed scenarios.
  int          acc, en_cnt, clr_cnt, done_cnt, busy_cnt, last_en, max_gap, clr_cyc, done_cyc;
  bit          done_with_en;
  logic [15:0] issued[$];

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("mac_en",    32'(mac_en),       32'(e_en));
      chk("mac_a",     32'(mac_a),        32'(e_a));
      chk("mac_b",     32'(mac_b),        32'(e_b));
      chk("mac_clr",   32'(mac_clr),      32'(e_clr));
      chk("busy",      32'(busy),         32'(e_busy));
      chk("done",      32'(done),         32'(e_done));
      chk("remaining", 32'(remaining),    32'(e_rem));
      chk("in_ready",  32'(bus.in_ready), 32'(q.size() < DEPTH));
      if (mac_clr) begin
        acc = 0;
        clr_cnt++;
        clr_cyc = cyc;
      end else if (mac_en) begin
        acc += int'(mac_a) * int'(mac_b);
      end
      if (mac_en) begin
        en_cnt++;
        issued.push_back({mac_a, mac_b});
        if (last_en >= 0 && cyc - last_en - 1 > max_gap) max_gap = cyc - last_en - 1;
        last_en = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (mac_en) done_with_en = 1;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_mon();
    acc = 0; en_cnt = 0; clr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    last_en = -1; max_gap = 0; clr_cyc = 0; done_cyc = 0; done_with_en = 0;
    issued.delete();
  endtask

  // All driver tasks are entered and left at a falling edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit ok = 0;
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b;
    while (!ok && n < 200) begin
      ok = bus.in_ready;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    start = 1; len = l;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0;
    clear_mon();

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    chk("rst_mac_en",    32'(mac_en),       32'd0);
    chk("rst_mac_clr",   32'(mac_clr),      32'd0);
    chk("rst_mac_ab",    32'({mac_a, mac_b}), 32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_done",      32'(done),         32'd0);
    chk("rst_remaining", 32'(remaining),    32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    rst = 0;
    @(negedge clk);

    // Basic dot product.
    clear_mon();
    push_pair(8'd3, 8'd4);
    push_pair(8'd2, 8'd5);
    push_pair(8'd10, 8'd10);
    pulse_start(8'd3);
    wait_done(1, 50);
    repeat (2) @(negedge clk);
    chk("basic_acc",      32'(acc),          32'h007A);
    chk("basic_en_cnt",   32'(en_cnt),       32'd3);
    chk("basic_clr_cnt",  32'(clr_cnt),      32'd1);
    chk("basic_done_en",  32'(done_with_en), 32'd1);
    chk("basic_gap",      32'(max_gap),      32'd0);
    chk("basic_pair0",    32'(issued[0]),    32'h0304);
    chk("basic_pair1",    32'(issued[1]),    32'h0205);
    chk("basic_pair2",    32'(issued[2]),    32'h0A0A);

    // Back-pressure: fifth pair waits until the first pop frees a slot.
    clear_mon();
    for (int i = 0; i < 4; i++) push_pair(8'(i + 1), 8'(8'h10 + i));
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1; bus.in_a = 8'd5; bus.in_b = 8'h14;
    repeat (2) @(negedge clk);
    chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
    start = 1; len = 8'd5;
    @(negedge clk);
    start = 0;
    n = 0; ok = 0;
    while (!ok && n < 50) begin
      ok = bus.in_ready;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 0;
    chk("bp_fifth_accepted", 32'(ok), 32'd1);
    wait_done(1, 60);
    @(negedge clk);
    chk("bp_en_cnt", 32'(en_cnt), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("bp_order", 32'(issued[i]), 32'({8'(i + 1), 8'(8'h10 + i)}));

    // Starvation.
    clear_mon();
    pulse_start(8'd2);
    push_pair(8'd7, 8'd9);
    repeat (4) @(negedge clk);
    chk("starve_rem_hold", 32'(remaining), 32'd1);
    chk("starve_en_mid",   32'(en_cnt),    32'd1);
    push_pair(8'd6, 8'd8);
    wait_done(1, 50);
    @(negedge clk);
    chk("starve_gap",    32'(max_gap >= 3), 32'd1);
    chk("starve_en_cnt", 32'(en_cnt),       32'd2);
    chk("starve_acc",    32'(acc),          32'd111);

    // Zero length.
    clear_mon();
    pulse_start(8'd0);
    wait_done(1, 20);
    repeat (2) @(negedge clk);
    chk("zero_en_cnt",   32'(en_cnt),             32'd0);
    chk("zero_clr_cnt",  32'(clr_cnt),            32'd1);
    chk("zero_busy_cnt", 32'(busy_cnt),           32'd2);
    chk("zero_clr_done", 32'(done_cyc - clr_cyc), 32'd1);

    // Reset in the middle of a run.
    clear_mon();
    for (int i = 0; i < 4; i++) push_pair(8'(8'h20 + i), 8'(8'h30 + i));
    pulse_start(8'd4);
    n = 0;
    while (en_cnt < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_two_en", 32'(en_cnt), 32'd2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_busy",     32'(busy),         32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rem",      32'(remaining),    32'd0);
    chk("mid_mac_en",   32'(mac_en),       32'd0);
    repeat (4) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    // Queued pairs must be gone: a new one-pair job starves until a push.
    pulse_start(8'd1);
    repeat (5) @(negedge clk);
    chk("mid_fifo_empty", 32'(en_cnt), 32'd2);
    push_pair(8'h55, 8'h02);
    wait_done(1, 20);
    @(negedge clk);
    chk("mid_new_pair", 32'(issued[2]), 32'h5502);

    // Randomised traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      start        = ($urandom_range(0, 7) == 0);
      len          = LEN_W'($urandom_range(0, 6));
      rst          = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    bus.in_valid = 0; start = 0; rst = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, operand-pair FIFO depth; power of two, at least 2.
REQ-002 Parameter LEN_W, default 8, width of the vector-length field and the remaining-pair counter.
REQ-003 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port start, input, 1, one-cycle request to begin a dot product.
REQ-006 Port len, input, LEN_W, number of operand pairs in the dot product; sampled with start.
REQ-007 Port in_valid, input, 1, operand pair on in_a/in_b is valid.
REQ-008 Port in_ready, output, 1, FIFO can accept a pair this cycle.
REQ-009 Ports in_a and in_b, input, 8 each, operand A and operand B.
REQ-010 Ports mac_a and mac_b, output, 8 each, registered operands to the downstream MAC.
REQ-011 Port mac_en, output, 1, registered; MAC accumulates mac_a*mac_b this cycle.
REQ-012 Port mac_clr, output, 1, registered; one-cycle accumulator clear.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port done, output, 1, one-cycle pulse at the end of a dot product.
REQ-015 Port remaining, output, LEN_W, pairs still to be issued in the current dot product.

Function
REQ-016 The FIFO SHALL accept a push when in_valid and in_ready are both high, in any FSM state.
REQ-017 in_ready SHALL equal NOT full, using registered occupancy only; no same-cycle bypass when full.
REQ-018 A pop SHALL take only an entry present before the current edge; no fall-through of a same-cycle push.
REQ-019 The FSM SHALL have exactly four states: IDLE, CLEAR, RUN, DONE.
REQ-020 IDLE: when start is high, the FSM SHALL latch len into remaining and move to CLEAR; otherwise it stays in IDLE.
REQ-021 CLEAR: mac_clr SHALL be high for exactly this one cycle; next state is DONE if remaining is 0, else RUN.
REQ-022 RUN: each cycle the FIFO is non-empty and remaining is greater than 0, the block SHALL pop one pair and drive it on mac_a/mac_b with mac_en high in the following cycle.
REQ-023 RUN: each pop SHALL decrement remaining by 1.
REQ-024 RUN: the pop that takes remaining to 0 SHALL move the FSM to DONE.
REQ-025 RUN with the FIFO empty (starvation): mac_en SHALL be 0, mac_a and mac_b SHALL be 0, and remaining SHALL hold.
REQ-026 Pairs SHALL be issued in push order, with at most one pair per cycle.
REQ-027 DONE: done SHALL be high for one cycle, then the FSM returns to IDLE.
REQ-028 The last mac_en pulse SHALL occur in the same cycle as done.
REQ-029 start SHALL be ignored while busy is high.
REQ-030 Pairs pushed beyond len SHALL remain queued for the next dot product.
REQ-031 Whenever mac_en is low, mac_a and mac_b SHALL be 0.
REQ-032 Latency: with an empty FIFO in RUN, a pair accepted at edge k SHALL be popped at edge k+1, and mac_en SHALL be high in the cycle following edge k+1.
REQ-033 len = 0: the block SHALL produce mac_clr, then done, and no mac_en pulses.

Reset
REQ-034 While rst is high at a clock edge: FSM to IDLE, FIFO emptied, remaining = 0.
REQ-035 While rst is high at a clock edge: mac_a, mac_b, mac_en, mac_clr, busy and done all cleared to 0.
REQ-036 After reset, in_ready SHALL be 1.
REQ-037 rst SHALL take priority over start and over FIFO push and pop.
REQ-038 rst asserted mid-RUN SHALL discard all queued pairs; no done pulse is produced.

Verification
REQ-039 Reset check: assert rst for 2 cycles -> all outputs 0, in_ready = 1, busy = 0.
REQ-040 Basic dot product: push (3,4), (2,5), (10,10), then start with len = 3 -> mac_clr for one cycle, then mac_en on 3 consecutive cycles carrying 3/4, 2/5, 10/10 in order, done on the third; downstream accumulator = 0x007A.
REQ-041 Back-pressure with DEPTH = 4:
- push 5 pairs while IDLE -> in_ready goes low after the 4th push; the 5th pair is held at the input.
- then start with len = 5 -> the 5th pair is accepted after the first pop; all 5 pairs issued in order.
REQ-042 Starvation: start with len = 2 and an empty FIFO; push 1 pair, wait 3 cycles, push 1 more -> mac_en gap of at least 3 cycles, remaining holds at 1 during the gap, then done.
REQ-043 Zero length: start with len = 0 -> mac_clr in the cycle after start, done in the next cycle, mac_en never asserted, busy high for exactly 2 cycles.
REQ-044 Reset mid-run: start with len = 4 after pushing 4 pairs, assert rst after the 2nd mac_en -> next cycle IDLE, FIFO empty, in_ready = 1, no done pulse.
